// File: rtl/reg_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_bank_ctrl_if
// Request/response bundle between a sel/wr requester and the register bank.
//   addr   : register address                      (master -> slave)
//   sel    : request valid                         (master -> slave)
//   wr     : 1 = write, 0 = read                   (master -> slave)
//   wdata  : write data                            (master -> slave)
//   wstrb  : byte enables, bit i covers byte i     (master -> slave)
//   ready  : bank can accept a request             (slave -> master)
//   rdata  : read data, zero while rvalid is low   (slave -> master)
//   rvalid : one-cycle pulse qualifying rdata      (slave -> master)
//   err    : one-cycle error pulse                 (slave -> master)
// ---------------------------------------------------------------------------
interface reg_bank_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   addr;
  logic                    sel;
  logic                    wr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    err;

  modport master (
    output addr, sel, wr, wdata, wstrb,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  addr, sel, wr, wdata, wstrb,
    output ready, rdata, rvalid, err
  );

endinterface

// File: rtl/reg_bank_ctrl.sv
// ---------------------------------------------------------------------------
// reg_bank_ctrl
// Memory-mapped register bank with byte-strobed writes, a configurable read
// latency (RD_LATENCY = 1..4) and a read-only region RO_BASE..DEPTH-1 that
// always reads RESET_VAL. One request is handled at a time; writes complete
// in IDLE, reads pass through RD_WAIT. Out-of-range reads and out-of-range or
// read-only writes produce a one-cycle err pulse.
//
// Ports
//   clk  : clock, all logic on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : reg_bank_ctrl_if.slave (addr/sel/wr/wdata/wstrb in,
//          ready/rdata/rvalid/err out, all outputs registered)
//
// Build option
//   REG_BANK_WSTRB_EN : when defined, wstrb selects the bytes to update;
//                       when undefined, every legal write updates the word.
// ---------------------------------------------------------------------------
module reg_bank_ctrl #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = DATA_WIDTH'(32'h0000_1234),
  parameter int                    RD_LATENCY = 2,
  parameter int                    RO_BASE    = 240
) (
  input  logic            clk,
  input  logic            rstn,
  reg_bank_ctrl_if.slave  bus
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  // Only the writable window needs storage; the RO region is a constant.
  localparam int WR_DEPTH = (RO_BASE < DEPTH) ? RO_BASE : DEPTH;
  localparam int MEM_N    = (WR_DEPTH > 0) ? WR_DEPTH : 1;
  localparam int IDX_W    = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] WR_LIM    = (ADDR_WIDTH+1)'(WR_DEPTH);
  localparam logic [1:0]          LAST_CNT  = 2'(RD_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t                  state_r;
  logic [1:0]              cnt_r;
  logic                    ready_r;
  logic                    rvalid_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [DATA_WIDTH-1:0]   hold_data_r;
  logic                    hold_err_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_N];

  logic                    in_range_s;
  logic                    writable_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    accept_s;
  logic                    wr_hit_s;
  logic [STRB_W-1:0]       strb_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;

  assign in_range_s = ({1'b0, bus.addr} < DEPTH_LIM);
  assign writable_s = ({1'b0, bus.addr} < WR_LIM);
  assign idx_s      = bus.addr[IDX_W-1:0];
  // ready_r is high exactly when the FSM is in IDLE.
  assign accept_s   = bus.sel & ready_r;
  assign wr_hit_s   = accept_s & bus.wr & writable_s;

`ifdef REG_BANK_WSTRB_EN
  assign strb_s = bus.wstrb;
`else
  // Strobes ignored: every lane is enabled whatever wstrb carries.
  assign strb_s = bus.wstrb | ~bus.wstrb;
`endif

  // RO addresses read the reset constant, out-of-range addresses read zero.
  assign rd_word_s = writable_s ? mem_r[idx_s]
                   : (in_range_s ? RESET_VAL : {DATA_WIDTH{1'b0}});

  // Register array: reset to RESET_VAL, byte-lane update on a legal write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_N; i++) begin
        mem_r[i] <= RESET_VAL;
      end
    end else if (wr_hit_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      ready_r     <= 1'b1;
      rvalid_r    <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      hold_data_r <= {DATA_WIDTH{1'b0}};
      hold_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 2'd0;
          if (accept_s && bus.wr) begin
            // Write completes here; only an error pulse is reported.
            err_r    <= ~writable_s;
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
          end else if (accept_s) begin
            // Sample the array now so a write from the previous edge is seen.
            state_r     <= RD_WAIT;
            ready_r     <= 1'b0;
            hold_data_r <= rd_word_s;
            hold_err_r  <= ~in_range_s;
            if (LAST_CNT == 2'd0) begin
              rvalid_r <= 1'b1;
              rdata_r  <= rd_word_s;
              err_r    <= ~in_range_s;
            end else begin
              rvalid_r <= 1'b0;
              rdata_r  <= {DATA_WIDTH{1'b0}};
              err_r    <= 1'b0;
            end
          end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            err_r    <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (cnt_r == LAST_CNT) begin
            state_r  <= IDLE;
            ready_r  <= 1'b1;
            cnt_r    <= 2'd0;
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            err_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 2'd1;
            // Response occupies the last cycle before ready returns.
            if ((cnt_r + 2'd1) == LAST_CNT) begin
              rvalid_r <= 1'b1;
              rdata_r  <= hold_data_r;
              err_r    <= hold_err_r;
            end else begin
              rvalid_r <= 1'b0;
              rdata_r  <= {DATA_WIDTH{1'b0}};
              err_r    <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 2'd0;
          ready_r  <= 1'b1;
          rvalid_r <= 1'b0;
          rdata_r  <= {DATA_WIDTH{1'b0}};
          err_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_ctrl
// Directed bench for reg_bank_ctrl. Instance u_a uses the default parameters
// (DEPTH 256, RD_LATENCY 2, RO_BASE 240); instance u_b uses DEPTH 200 and
// RD_LATENCY 4. Both share the request lines; tgt picks the target instance.
// ---------------------------------------------------------------------------
module tb_reg_bank_ctrl;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic        clk;
  logic        rstn_a;
  logic        rstn_b;
  bit          tgt;
  logic [7:0]  addr;
  logic        sel;
  logic        wr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        ready_m;
  logic        rvalid_m;
  logic        err_m;
  logic [31:0] rdata_m;

  int total;
  int bad;

  reg_bank_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_a ();
  reg_bank_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.addr  = addr;
  assign bus_a.wr    = wr;
  assign bus_a.wdata = wdata;
  assign bus_a.wstrb = wstrb;
  assign bus_a.sel   = sel & ~tgt;
  assign bus_b.addr  = addr;
  assign bus_b.wr    = wr;
  assign bus_b.wdata = wdata;
  assign bus_b.wstrb = wstrb;
  assign bus_b.sel   = sel & tgt;

  assign ready_m  = tgt ? bus_b.ready  : bus_a.ready;
  assign rvalid_m = tgt ? bus_b.rvalid : bus_a.rvalid;
  assign err_m    = tgt ? bus_b.err    : bus_a.err;
  assign rdata_m  = tgt ? bus_b.rdata  : bus_a.rdata;

  reg_bank_ctrl u_a (
    .clk  (clk),
    .rstn (rstn_a),
    .bus  (bus_a)
  );

  reg_bank_ctrl #(
    .DEPTH      (200),
    .RD_LATENCY (LAT_B)
  ) u_b (
    .clk  (clk),
    .rstn (rstn_b),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write accepted at the next edge; err checked for exactly one cycle.
  task automatic wr_req(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic exp_err, input string tag);
    addr = a; wr = 1'b1; wdata = d; wstrb = s; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
    chk({tag, "_err"}, 32'(err_m), 32'(exp_err));
    chk({tag, "_rdy"}, 32'(ready_m), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_err_end"}, 32'(err_m), 32'd0);
  endtask

  // Read with data, error and full latency/handshake checks.
  task automatic rd_req(input logic [7:0] a, input logic [31:0] exp_data,
                        input logic exp_err, input string tag);
    int lat      = tgt ? LAT_B : LAT_A;
    int rv_n     = 0;
    int rv_at    = -1;
    int nr_n     = 0;
    int er_n     = 0;
    int idle_bad = 0;
    logic [31:0] got = 32'd0;
    logic        ge  = 1'b0;
    addr = a; wr = 1'b0; sel = 1'b1;
    for (int i = 0; i < lat + 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) sel = 1'b0;
      if (rvalid_m) begin
        rv_n++;
        if (rv_at < 0) begin
          rv_at = i;
          got   = rdata_m;
          ge    = err_m;
        end
      end else if (rdata_m != 32'd0) begin
        idle_bad++;
      end
      if (!ready_m) nr_n++;
      if (err_m) er_n++;
    end
    chk({tag, "_data"},   got, exp_data);
    chk({tag, "_err"},    32'(ge), 32'(exp_err));
    chk({tag, "_lat"},    32'(rv_at), 32'(lat - 1));
    chk({tag, "_pulses"}, 32'(rv_n), 32'd1);
    chk({tag, "_busy"},   32'(nr_n), 32'(lat));
    chk({tag, "_errcnt"}, 32'(er_n), 32'(exp_err));
    chk({tag, "_idle0"},  32'(idle_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_merge;
    logic [31:0] exp_zero;
    logic [7:0]  rv_vec;
    logic [7:0]  rdy_vec;
    int          rv_n;

`ifdef REG_BANK_WSTRB_EN
    exp_merge = 32'h00BB_12DD;
    exp_zero  = 32'h0000_1234;
`else
    exp_merge = 32'hAABB_CCDD;
    exp_zero  = 32'h5555_5555;
`endif

    total = 0; bad = 0;
    tgt = 1'b0; addr = 8'h00; sel = 1'b0; wr = 1'b0;
    wdata = 32'd0; wstrb = 4'h0;
    rstn_a = 1'b0; rstn_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(ready_m), 32'd1);
    chk("rst_rvalid", 32'(rvalid_m), 32'd0);
    chk("rst_rdata",  rdata_m, 32'd0);
    chk("rst_err",    32'(err_m), 32'd0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(posedge clk); #1;

    // Reset values across the array and the RO region.
    rd_req(8'h00, 32'h0000_1234, 1'b0, "rv_00");
    rd_req(8'h7F, 32'h0000_1234, 1'b0, "rv_7f");
    rd_req(8'hEF, 32'h0000_1234, 1'b0, "rv_ef");

    // Byte-strobe write and the empty-strobe write.
    wr_req(8'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, "w_strb");
    rd_req(8'h10, exp_merge, 1'b0, "r_strb");
    wr_req(8'h20, 32'h5555_5555, 4'b0000, 1'b0, "w_zero");
    rd_req(8'h20, exp_zero, 1'b0, "r_zero");

    // Back-to-back writes on consecutive edges.
    addr = 8'h30; wr = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF; sel = 1'b1;
    @(posedge clk); #1;
    chk("b2b_rdy", 32'(ready_m), 32'd1);
    addr = 8'h31; wdata = 32'h2222_2222;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
    chk("b2b_err", 32'(err_m), 32'd0);
    rd_req(8'h30, 32'h1111_1111, 1'b0, "r_b2b0");
    rd_req(8'h31, 32'h2222_2222, 1'b0, "r_b2b1");

    // Last writable address, then the read-only region.
    wr_req(8'hEF, 32'h0BAD_BEEF, 4'hF, 1'b0, "w_ef");
    rd_req(8'hEF, 32'h0BAD_BEEF, 1'b0, "r_ef");
    wr_req(8'hF0, 32'hFFFF_FFFF, 4'hF, 1'b1, "w_ro");
    rd_req(8'hF0, 32'h0000_1234, 1'b0, "r_ro");
    rd_req(8'hFF, 32'h0000_1234, 1'b0, "r_ro_top");

    // sel held through a read: next acceptance no earlier than N+3.
    addr = 8'h10; wr = 1'b0; sel = 1'b1;
    rv_vec = 8'd0; rdy_vec = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rv_vec[i]  = rvalid_m;
      rdy_vec[i] = ready_m;
      if (i == 5) sel = 1'b0;
    end
    chk("hold_rvalid", 32'(rv_vec), 32'h0000_0012);
    chk("hold_ready",  32'(rdy_vec), 32'h0000_00E4);

    // Instance B: DEPTH 200, RD_LATENCY 4.
    tgt = 1'b1;
    @(posedge clk); #1;
    wr_req(8'hD0, 32'hFFFF_FFFF, 4'hF, 1'b1, "b_w_oor");
    rd_req(8'hD0, 32'h0000_0000, 1'b1, "b_r_oor");
    rd_req(8'h50, 32'h0000_1234, 1'b0, "b_r_alias");
    wr_req(8'hC7, 32'h1234_5678, 4'hF, 1'b0, "b_w_c7");
    rd_req(8'hC7, 32'h1234_5678, 1'b0, "b_r_c7");
    wr_req(8'h05, 32'hDEAD_BEEF, 4'hF, 1'b0, "b_w_05");
    rd_req(8'h05, 32'hDEAD_BEEF, 1'b0, "b_r_05");

    // Reset asserted two cycles after a read is accepted.
    rv_n = 0;
    addr = 8'h05; wr = 1'b0; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
    if (rvalid_m) rv_n++;
    @(posedge clk); #1;
    if (rvalid_m) rv_n++;
    @(posedge clk); #1;
    rstn_b = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(ready_m), 32'd1);
    chk("mid_rst_rvalid", 32'(rvalid_m), 32'd0);
    chk("mid_rst_err",    32'(err_m), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rvalid_m) rv_n++;
    end
    rstn_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rvalid_m) rv_n++;
    end
    chk("mid_rst_no_rvalid", 32'(rv_n), 32'd0);
    rd_req(8'h05, 32'h0000_1234, 1'b0, "b_r_05_rst");
    rd_req(8'hC7, 32'h0000_1234, 1'b0, "b_r_c7_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Parametrised successor to the single-cycle register controller: a memory-mapped register bank with byte-strobed writes, configurable read latency, and a read-only upper region. Out-of-range and illegal accesses return an error response. It sits between a simple sel/wr requester (CPU bus bridge or testbench driver) and block-level control/status registers. Accepts one request at a time using a ready handshake.

## Interface
- ADDR_WIDTH, 8, address width
- DATA_WIDTH, 32, register width; must be a multiple of 8
- DEPTH, 256, number of implemented registers; must be ≤ 2**ADDR_WIDTH
- RESET_VAL, 32'h0000_1234, reset value of every register
- RD_LATENCY, 2, read latency in cycles, legal range 1..4
- RO_BASE, 240, first read-only address; registers RO_BASE..DEPTH-1 are read-only
- clk  input  1  clock; all logic on rising edge
- rstn  input  1  reset, asynchronous, active-low
- addr  input  ADDR_WIDTH  register address
- sel  input  1  request valid
- wr  input  1  1 = write, 0 = read
- wdata  input  DATA_WIDTH  write data
- wstrb  input  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- ready  output  1  bank can accept a request
- rdata  output  DATA_WIDTH  read data; 0 whenever rvalid=0
- rvalid  output  1  one-cycle pulse qualifying rdata
- err  output  1  one-cycle error pulse

## Operation
- **Reset values.** While rstn=0, all registers are set to RESET_VAL. Outputs are ready=1, rvalid=0, rdata=0, err=0.
- **Acceptance.** A request is accepted at a rising edge when sel & ready. If sel is high while ready=0, the request is ignored and the requester must hold it.
- **FSM states.**
  - IDLE (ready=1).
  - RD_WAIT: latency counter, 0..RD_LATENCY-1.
  - Writes never leave IDLE.
- **Write.** At the acceptance edge, each byte with wstrb[i]=1 is updated. Other bytes are unchanged.
  - wstrb=0 updates nothing and raises no error.
  - Next request can be accepted on the following edge.
- **Write error.** addr ≥ DEPTH or addr ≥ RO_BASE: no register is modified. err=1 for exactly the cycle after the acceptance edge.
- **Read.** The array is sampled at the acceptance edge, so a write accepted on the previous edge is visible. The FSM enters RD_WAIT.
- **Read error.** addr ≥ DEPTH: rdata=0 and err=1, aligned with the rvalid pulse. Reads of the RO region are legal.
- **Read-only region.** RO registers hold RESET_VAL permanently.

## Timing
- Read accepted at edge N (RD_LATENCY = L):
  - ready=0 from edge N until edge N+L.
  - rvalid=1 (with rdata, and err if applicable) from edge N+L-1 until edge N+L.
  - ready=1 again from edge N+L. Earliest next acceptance is edge N+L+1.
  - Read throughput is one per L+1 cycles.
- L=1: rvalid and rdata appear right after the acceptance edge.
- Write accepted at edge N: register is updated at N. Write-err pulse runs from N to N+1. ready stays 1.
- Back-to-back writes are sustained at one per cycle.
- Reset asserted mid-read: the read is aborted immediately and asynchronously. No rvalid is produced, the FSM goes to IDLE, and outputs take their reset values.
- Requester inputs are sampled only at acceptance edges.

## Configuration
- REG_BANK_WSTRB_EN defined: byte strobes are honoured as described above.
- REG_BANK_WSTRB_EN undefined: wstrb is ignored and every legal write updates the full word. The wstrb=0 write is then a full-word write.

## Test plan
- **Reset values.** Release rstn, then read addr 0x00, 0x7F and 0xEF → each read returns 32'h0000_1234 with err=0.
- **Byte-strobe write.** Write 0xAABBCCDD to 0x10 with wstrb=4'b0101, then read 0x10.
  - With REG_BANK_WSTRB_EN: returns 0x0000_12… per byte, i.e. 0x00BB_12DD; checked against byte-merge 0x00BB12DD.
  - Without REG_BANK_WSTRB_EN: returns 0xAABBCCDD.
- **Read latency.** With L=2, read accepted at edge N → ready low for exactly 2 cycles, rvalid high for exactly the cycle between edges N+1 and N+2. A sel pulse held during that window is accepted at edge N+3 at the earliest.
- **Read-only region.** Write 0xFFFF_FFFF to 0xF0 → err pulse 1 cycle after acceptance. A subsequent read of 0xF0 returns 32'h0000_1234.
- **Out-of-range access.** With DEPTH=200:
  - Write to 0xD0 → err=1 and no register changes.
  - Read of 0xD0 → rdata=0 and err=1, coincident with rvalid.
- **Reset mid-read.** L=4; assert rstn low 2 cycles after read acceptance → rvalid never pulses and ready=1 during reset. All registers read 32'h0000_1234 after release.
